// File: rtl/adder32_arbiter.sv
// Round-robin front end that time-shares one external W-bit adder among NREQ requesters
// and returns each sum on a single registered response channel tagged with the requester id.
//
// state | meaning
// IDLE  | accepting: one-hot grant to the round-robin winner
// CALC  | captured operands drive the adder for one cycle
// RESP  | response held until rsp_ready
module adder32_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_ci,
    input  logic [W-1:0]      add_s,
    input  logic              add_co,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [IDW-1:0]    rsp_id
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic           op_ci_q, op_ci_d;
    logic [IDW-1:0] id_q, id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_sum_q, rsp_sum_d;
    logic           rsp_cout_q, rsp_cout_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;

    logic [IDW-1:0] win, lo_idx, hi_idx;
    logic           hi_any, any_valid;

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        hi_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = IDW'(i);
            end
            if (req_valid[i] && (i >= int'(rr_ptr_q))) begin
                hi_idx = IDW'(i);
                hi_any = 1'b1;
            end
        end
        win = hi_any ? hi_idx : lo_idx;
    end

    assign any_valid = |req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_ci_d     = op_ci_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (any_valid && !rst) begin
                    req_ready[win] = 1'b1;
                end
                if (any_valid) begin
                    op_a_d   = req_a[int'(win)*W +: W];
                    op_b_d   = req_b[int'(win)*W +: W];
                    op_ci_d  = req_cin[win];
                    id_d     = win;
                    rr_ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
                end
            end
            CALC: begin
                rsp_sum_d   = add_s;
                rsp_cout_d  = add_co;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_ci_q     <= 1'b0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_ci_q     <= op_ci_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign add_a     = op_a_q;
    assign add_b     = op_b_q;
    assign add_ci    = op_ci_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder32_arbiter.sv
// Directed bench for adder32_arbiter; the external adder is modelled here as A + B + Ci.
module tb_adder32_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_ci;
    logic [W-1:0]      add_s;
    logic              add_co;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};

    adder32_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
        .add_s(add_s), .add_co(add_co),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [1:0] eid;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;

        // Reset state, including req_ready gated while a request is present.
        tick();
        req_valid = 4'b0001;
        settle();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_add_a", add_a, 0);
        tick();
        rst = 1'b0;

        // Single request on req0.
        req_a[0*W +: W] = 32'hFFC0_0FFC;
        req_b[0*W +: W] = 32'hFFFF_F003;
        rsp_ready = 1'b1;
        settle();
        chk("t1_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        settle();
        chk("t1_calc_ready", req_ready, 0);
        chk("t1_calc_add_a", add_a, 32'hFFC0_0FFC);
        chk("t1_calc_valid", rsp_valid, 0);
        tick();
        chk("t1_valid", rsp_valid, 1);
        chk("t1_sum", rsp_sum, 32'hFFBF_FFFF);
        chk("t1_cout", rsp_cout, 1);
        chk("t1_id", rsp_id, 0);
        tick();
        chk("t1_done_valid", rsp_valid, 0);
        chk("t1_hold_sum", rsp_sum, 32'hFFBF_FFFF);

        // Carry-in wrap on req2 (rr_ptr=1, scan reaches 2).
        req_a[2*W +: W] = 32'hFFFF_FFFF;
        req_b[2*W +: W] = 32'h0000_0000;
        req_cin[2] = 1'b1;
        req_valid = 4'b0100;
        settle();
        chk("t2_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick();
        chk("t2_valid", rsp_valid, 1);
        chk("t2_sum", rsp_sum, 32'h0000_0000);
        chk("t2_cout", rsp_cout, 1);
        chk("t2_id", rsp_id, 2);
        tick();

        // Reset during CALC of req3 discards the operation.
        req_a[3*W +: W] = 32'h5;
        req_b[3*W +: W] = 32'h7;
        req_valid = 4'b1000;
        settle();
        chk("t3_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        settle();
        chk("t3_calc_add_a", add_a, 32'h5);
        rst = 1'b1;
        settle();
        chk("t3_rst_valid", rsp_valid, 0);
        chk("t3_rst_sum", rsp_sum, 0);
        chk("t3_rst_cout", rsp_cout, 0);
        chk("t3_rst_id", rsp_id, 0);
        chk("t3_rst_add_a", add_a, 0);
        chk("t3_rst_add_ci", add_ci, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_no_stale", rsp_valid, 0);
        end

        // Round-robin with all four requesters valid.
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'(i);
            req_b[i*W +: W] = 32'h10;
        end
        req_cin = '0;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            eid = 2'(k % NREQ);
            settle();
            chk("rr_grant", req_ready, 4'b0001 << eid);
            tick();
            chk("rr_calc_ready", req_ready, 0);
            tick();
            chk("rr_valid", rsp_valid, 1);
            chk("rr_sum", rsp_sum, 32'h10 + 32'(eid));
            chk("rr_id", rsp_id, eid);
            tick();
        end

        // Backpressure: req0 response held while req1 waits (rr_ptr=1 would favour req1 if both valid).
        req_a[0*W +: W] = 32'h1234_5678;
        req_b[0*W +: W] = 32'h1111_1111;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        settle();
        chk("bp_grant0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0010;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_sum", rsp_sum, 32'h2345_6789);
            chk("bp_id", rsp_id, 0);
            chk("bp_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_rel_valid", rsp_valid, 0);
        chk("bp_grant1", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        tick();
        chk("bp_r1_valid", rsp_valid, 1);
        chk("bp_r1_sum", rsp_sum, 32'h11);
        chk("bp_r1_id", rsp_id, 1);
        tick();

        // Idle with no requests.
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_ready", req_ready, 0);
            chk("idle_valid", rsp_valid, 0);
        end
        chk("idle_hold_id", rsp_id, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
